// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types, opcodes and helpers for the fetch front end
// Revision  : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE      = 2'd0;
    localparam fetch_state_t WAIT      = 2'd1;
    localparam fetch_state_t WAIT_KILL = 2'd2;

    localparam logic [5:0] OPC_J = 6'b000010;

    // Operates at 64 bits so any XLEN up to 64 can truncate the result.
    function automatic logic [63:0] jump_target(input logic [63:0] pc_plus_4,
                                                input logic [31:0] inst);
        return (pc_plus_4 & ~64'h0FFF_FFFF) | {36'd0, inst[25:0], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : prefetch queue with synchronous flush and registered head
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_head;
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    w_rd_next;
    logic [PW:0]      r_count;
    logic [PW:0]      w_count_next;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != (PW+1)'(DEPTH)) || w_pop);

    always_comb begin
        w_rd_next    = w_pop ? r_rd + PW'(1) : r_rd;
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (PW+1)'(1);
            2'b01:   w_count_next = r_count - (PW+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

    // The head register is loaded with whatever entry the read pointer will
    // address next, bypassing the array when that entry is written now.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            r_rd    <= w_rd_next;
            r_count <= w_count_next;
            if (w_count_next == '0) begin
                r_head <= '0;
            end else if (w_push && (r_wr == w_rd_next)) begin
                r_head <= i_wdata;
            end else begin
                r_head <= r_mem[w_rd_next];
            end
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : PC sequencer, single-outstanding imem handshake, prefetch queue
// Optional J-type predecode at fetch time: FETCH_JUMP_PREDECODE_EN
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dq_valid,
    input  logic            dq_ready,
    output logic [31:0]     dq_inst,
    output logic [XLEN-1:0] dq_pc_plus_4,
    output logic            dq_predicted
);

    localparam int WIDTH = 32 + XLEN + 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_plus_4;
    logic [XLEN-1:0] w_next_pc;
    logic            w_pred;
    logic            w_take;
    logic            w_pop;
    logic [CW-1:0]   w_count;
    logic [WIDTH-1:0] w_head;

    assign w_pc_plus_4 = r_pc + XLEN'(4);

`ifdef FETCH_JUMP_PREDECODE_EN
    assign w_pred    = (imem_rdata[31:26] == OPC_J);
    assign w_next_pc = w_pred ? XLEN'(jump_target(64'(w_pc_plus_4), imem_rdata))
                              : w_pc_plus_4;
`else
    assign w_pred    = 1'b0;
    assign w_next_pc = w_pc_plus_4;
`endif

    // A redirect cycle never issues: the old-PC request would otherwise leave
    // an untracked response outstanding while the FSM stays in IDLE.
    assign imem_req  = !reset && !redirect && (r_state == IDLE)
                       && (32'(w_count) < DEPTH);
    assign imem_addr = r_pc;

    assign w_take = (r_state == WAIT) && imem_ack && !redirect;
    assign w_pop  = dq_valid && dq_ready && !redirect;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_state <= IDLE;
        end else if (redirect) begin
            r_pc <= redirect_pc;
            case (r_state)
                WAIT, WAIT_KILL: r_state <= imem_ack ? IDLE : WAIT_KILL;
                default:         r_state <= IDLE;
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    if (imem_req) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        r_pc    <= w_next_pc;
                        r_state <= IDLE;
                    end
                end
                WAIT_KILL: begin
                    if (imem_ack) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_flush (redirect),
        .i_push  (w_take),
        .i_wdata ({imem_rdata, w_pc_plus_4, w_pred}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign dq_valid     = (w_count != '0);
    assign dq_inst      = w_head[WIDTH-1 -: 32];
    assign dq_pc_plus_4 = w_head[XLEN:1];
    assign dq_predicted = w_head[0];

endmodule

`default_nettype wire
